seq_right_shifter: RTL and testbench
====================================

Name: seq_right_shifter

Overview:
Iterative right-shift unit, the companion to the 4-bit left barrel shifter in the arithmetic unit. Performs logical, arithmetic or rotate right shifts one bit position per clock. Uses a start/busy/done handshake so the HP-AU control path can issue shifts and collect registered results. Result is held on y until the next accepted operation.

Parameters:
WIDTH, 4, data width of a and y
SHAMT_W, 2, width of shift_amt; maximum shift is 2^SHAMT_W-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new operation; sampled only in IDLE
a  input  WIDTH  operand, sampled with start
shift_amt  input  SHAMT_W  shift distance, sampled with start
mode  input  2  00 logical, 01 arithmetic, 10 rotate right, 11 reserved (treated as logical); sampled with start
busy  output  1  high while an operation is in progress (SHIFT or DONE)
done  output  1  one-cycle pulse: y holds the new result
y  output  WIDTH  registered result

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, y=0, done=0, busy=0, internal work/count/mode registers cleared. Reset mid-operation aborts the operation; no done pulse follows, and y reads 0.
- States: IDLE, SHIFT, DONE. busy = (state != IDLE), registered or decoded with no combinational path from start.
- IDLE: if start=1 at edge T, latch work<=a, cnt<=shift_amt, mode_r<=mode. Go to SHIFT if shift_amt!=0, else go to DONE with y<=a.
- SHIFT: each cycle, work is shifted right by one position and cnt decrements.
  - Logical: MSB filled with 0.
  - Arithmetic: MSB replicated from work[WIDTH-1].
  - Rotate: MSB receives work[0].
  - When cnt==1, the final shifted value is written to y and the state moves to DONE. SHIFT therefore lasts exactly shift_amt cycles.
- DONE: done=1 for exactly one cycle, then return to IDLE. done is low in every other state.
- Latency: with start accepted at edge T, done is high during the cycle after edge T+shift_amt+1 (T+1 for shift_amt=0). Worst case for default parameters is 4 cycles.
- start while busy=1 is ignored. a, shift_amt and mode are not re-sampled, and the in-flight operation is unaffected.
- Back-to-back operation: start may be asserted in the cycle following done (state IDLE). Minimum issue interval is shift_amt+2 cycles.
- y changes only on the transition into DONE (or on reset) and is stable at all other times, including while the next operation runs.
- Arithmetic rules: shifting by WIDTH-1 in logical mode leaves only the original MSB at bit 0. Rotate by any amount never loses bits. Mode 11 behaves identically to 00.
- No X propagation: every register has a reset value, and all outputs are driven in every state.

Test Plan:
1. Identity: a=1011, shift_amt=0, mode=00, start pulse -> done one cycle later, y=1011, busy low the following cycle.
2. Logical vs. arithmetic: a=1011, shift_amt=1, mode=00 -> y=0101, done at T+2. Then a=1011, shift_amt=2, mode=01 -> y=1110, done at T+3.
3. Rotate and drop-off: a=0011, shift_amt=1, mode=10 -> y=1001. a=1100, shift_amt=3, mode=00 -> y=0001, done at T+4. a=1100, shift_amt=3, mode=11 -> y=0001.
4. Busy protection: start a=1000, shift_amt=3, mode=01. Assert start with a=0001, shift_amt=0 during SHIFT -> ignored, y=1111 at done, single done pulse, y unchanged afterwards.
5. Reset mid-operation: start a=1011, shift_amt=3. Pull rst_n low asynchronously during SHIFT -> busy=0, done=0, y=0 immediately, no later done pulse. After release, a fresh shift of 0110 by 1 (mode 00) -> y=0011.
6. Back-to-back: assert start in the cycle after done with a=0101, shift_amt=2, mode=10 -> accepted, y=0101. Check y held at the previous value until the new done.

Source files
------------

// File: rtl/seq_right_shifter_if.sv
// Handshake and data bundle for seq_right_shifter.
//   start     : request a new operation (sampled only while idle)
//   a         : operand, sampled with start
//   shift_amt : shift distance, sampled with start
//   mode      : 00 logical, 01 arithmetic, 10 rotate right, 11 as logical
//   busy      : operation in progress
//   done      : one-cycle pulse, y holds the new result
//   y         : registered result
// master drives the request side, slave is the shifter.
interface seq_right_shifter_if #(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = 2
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [SHAMT_W-1:0] shift_amt;
  logic [1:0]         mode;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   y;

  modport master (
    output start, a, shift_amt, mode,
    input  busy, done, y
  );

  modport slave (
    input  start, a, shift_amt, mode,
    output busy, done, y
  );
endinterface

// File: rtl/seq_right_shifter.sv
// Iterative right shifter: one bit position per clock, logical, arithmetic
// or rotate. A start accepted in IDLE latches operand, distance and mode;
// the result lands on y together with a one-cycle done pulse and is held
// until the next operation completes.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_right_shifter_if slave (start/a/shift_amt/mode in,
//           busy/done/y out)
module seq_right_shifter #(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_right_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_ASR = 2'b01,
    MODE_ROR = 2'b10,
    MODE_RSV = 2'b11
  } shift_mode_t;

  state_t             state;
  shift_mode_t        mode_r;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   shifted;
  logic               fill;

  // Bit entering at the MSB for one step of the latched mode.
  always_comb begin
    fill = 1'b0;
    case (mode_r)
      MODE_ASR: fill = work[WIDTH-1];
      MODE_ROR: fill = work[0];
      default:  fill = 1'b0;
    endcase
    shifted = {fill, work[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_r   <= MODE_LSR;
      work     <= '0;
      cnt      <= '0;
      bus.y    <= '0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            work     <= bus.a;
            cnt      <= bus.shift_amt;
            mode_r   <= shift_mode_t'(bus.mode);
            bus.busy <= 1'b1;
            if (bus.shift_amt == '0) begin
              // Zero distance skips SHIFT and publishes the operand directly.
              bus.y    <= bus.a;
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end

        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            bus.y    <= shifted;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_right_shifter.sv
// Self-checking bench for seq_right_shifter (WIDTH=4, SHAMT_W=2).
// A cycle-level behavioural model predicts busy/done/y from accepted
// requests and arithmetic shift results; a negedge process compares the
// DUT against it every cycle. Directed cases pin literal results.
module tb_seq_right_shifter;

  localparam int W = 4;
  localparam int S = 2;

  logic clk;
  logic rst_n;

  seq_right_shifter_if #(.WIDTH(W), .SHAMT_W(S)) bus();

  seq_right_shifter #(.WIDTH(W), .SHAMT_W(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input int unsigned n,
                                             input logic [1:0] m);
    logic [2*W-1:0] t;
    case (m)
      2'b01:   return W'($signed(v) >>> n);
      2'b10: begin
        t = {v, v} >> n;
        return t[W-1:0];
      end
      default: return v >> n;
    endcase
  endfunction

  // Behavioural model: done appears n edges after acceptance (same edge for n=0)
  // and busy drops one edge after that.
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;
  logic [W-1:0] exp_y    = '0;
  logic [W-1:0] res      = '0;
  bit           active   = 1'b0;
  int           cyc      = 0;
  int           done_edge = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_y    = '0;
        active   = 1'b0;
      end else begin
        cyc++;
        if (active) begin
          if (cyc == done_edge) begin
            exp_y    = res;
            exp_done = 1'b1;
          end else if (cyc == done_edge + 1) begin
            exp_done = 1'b0;
            exp_busy = 1'b0;
            active   = 1'b0;
          end
        end else if (bus.start) begin
          active    = 1'b1;
          exp_busy  = 1'b1;
          done_edge = cyc + int'(bus.shift_amt);
          res       = ref_shift(bus.a, int'(bus.shift_amt), bus.mode);
          if (bus.shift_amt == '0) begin
            exp_y    = res;
            exp_done = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", 32'(bus.busy), 32'(exp_busy));
        check("done", 32'(bus.done), 32'(exp_done));
        check("y",    32'(bus.y),    32'(exp_y));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [S-1:0] n, input logic [1:0] m);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.a         = a;
    bus.shift_amt = n;
    bus.mode      = m;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits for done; lat is the number of negedges expected from now.
  task automatic wait_done(input string name, input int lat, input logic [W-1:0] exp);
    int k = 0;
    while (!bus.done && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done want done", name);
    end else begin
      check({name, "_lat"}, 32'(k), 32'(lat));
      check({name, "_y"},   32'(bus.y), 32'(exp));
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [S-1:0] n,
                        input logic [1:0] m, input logic [W-1:0] exp);
    check({name, "_model"}, 32'(ref_shift(a, int'(n), m)), 32'(exp));
    issue(a, n, m);
    wait_done(name, int'(n), exp);
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.start     = 1'b0;
    bus.a         = '0;
    bus.shift_amt = '0;
    bus.mode      = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_y",    32'(bus.y),    32'd0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Identity and basic modes
    run_op("ident", 4'b1011, 2'd0, 2'b00, 4'b1011);
    @(negedge clk);
    check("ident_busy_after", 32'(bus.busy), 32'd0);
    run_op("lsr1",  4'b1011, 2'd1, 2'b00, 4'b0101);
    run_op("asr2",  4'b1011, 2'd2, 2'b01, 4'b1110);
    run_op("ror1",  4'b0011, 2'd1, 2'b10, 4'b1001);
    run_op("lsr3",  4'b1100, 2'd3, 2'b00, 4'b0001);
    run_op("rsv3",  4'b1100, 2'd3, 2'b11, 4'b0001);
    run_op("ror3",  4'b0110, 2'd3, 2'b10, 4'b1100);

    // Start while busy must be ignored
    check("busy_model", 32'(ref_shift(4'b1000, 3, 2'b01)), 32'(4'b1111));
    issue(4'b1000, 2'd3, 2'b01);
    bus.start     = 1'b1;
    bus.a         = 4'b0001;
    bus.shift_amt = 2'd0;
    bus.mode      = 2'b00;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busyprot", 2, 4'b1111);
    repeat (4) @(negedge clk);
    check("busyprot_hold", 32'(bus.y), 32'(4'b1111));

    // Asynchronous reset in the middle of SHIFT
    issue(4'b1011, 2'd3, 2'b00);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_y",    32'(bus.y),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run_op("postrst", 4'b0110, 2'd1, 2'b00, 4'b0011);

    // Back-to-back: start in the idle cycle right after done
    issue(4'b0101, 2'd2, 2'b10);
    check("b2b_accepted", 32'(bus.busy), 32'd1);
    check("b2b_y_held",   32'(bus.y),    32'(4'b0011));
    wait_done("b2b", 2, 4'b0101);

    // Randomized traffic, including start noise while busy
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.start     = ($urandom_range(0, 99) < 60);
      bus.a         = W'($urandom);
      bus.shift_amt = S'($urandom);
      bus.mode      = 2'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
